mem_port: RTL and testbench

Memory-side responder for the 8-bit microprocessor's control-unit strobes. Owns the program counter, memory address register, memory buffer register and a single-port 2^ADDR_W x DATA_W RAM, and executes the fetch/store requests the control unit issues through MAR_we, MBR_we, RAM_we and PC_inc. A configurable wait-state counter and a mem_rdy handshake let the control unit stall on slow memory instead of assuming single-cycle access.

---
 rtl/mem_port.sv | 115 +++++++++++
 tb/tb_mem_port.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port.sv
// Memory-side responder: pc, mar, mbr and RAM behind a wait-state handshake.
// Define MEM_PORT_WPROT_EN to block writes below PROT_LIMIT and flag prot_err.
module mem_port #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_LIMIT  = 16
) (
    input  logic              mem_clk,
    input  logic              mem_rst_n,
    input  logic              MAR_we,
    input  logic [1:0]        RAM_in,
    input  logic              PC_inc,
    input  logic              MBR_we,
    input  logic              RAM_we,
    input  logic [ADDR_W-1:0] ir_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              mem_rdy,
    output logic [DATA_W-1:0] mbr,
    output logic [ADDR_W-1:0] mar,
    output logic [ADDR_W-1:0] pc,
    output logic              prot_err
);

`ifdef MEM_PORT_WPROT_EN
    localparam bit PROT_EN = 1'b1;
`else
    localparam bit PROT_EN = 1'b0;
`endif

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state;
    logic              op_wr;
    logic [DATA_W-1:0] wbuf;
    logic [3:0]        cnt;
    logic              acc_edge;
    logic              wr_blk;
    logic              ram_wr;

    logic [DATA_W-1:0] ram [2**ADDR_W];

    assign acc_edge = (state == BUSY) && (cnt == 4'd0);
    assign wr_blk   = PROT_EN && (mar < ADDR_W'(PROT_LIMIT));
    assign ram_wr   = acc_edge && op_wr && !wr_blk;

    // RAM has no reset; an async reset drops state to IDLE, killing ram_wr.
    always_ff @(posedge mem_clk) begin
        if (ram_wr)
            ram[mar] <= wbuf;
    end

`ifdef MEM_PORT_WPROT_EN
    logic prot_q;

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n)
            prot_q <= 1'b0;
        else
            prot_q <= acc_edge && op_wr && wr_blk;
    end

    assign prot_err = prot_q;
`else
    assign prot_err = 1'b0;
`endif

    always_ff @(posedge mem_clk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            mar     <= '0;
            mbr     <= '0;
            mem_rdy <= 1'b1;
            op_wr   <= 1'b0;
            wbuf    <= '0;
            cnt     <= 4'd0;
        end else begin
            if (PC_inc)
                pc <= pc + 1'b1;
            case (state)
                IDLE: begin
                    // mar only moves while idle so an access sees a stable address
                    if (MAR_we) begin
                        case (RAM_in)
                            2'b00:   mar <= pc;
                            2'b01:   mar <= ir_addr;
                            2'b10:   mar <= mbr[ADDR_W-1:0];
                            default: mar <= mar;
                        endcase
                    end
                    if (RAM_we || MBR_we) begin
                        op_wr   <= RAM_we;
                        wbuf    <= wr_data;
                        cnt     <= 4'(WAIT_CYCLES);
                        state   <= BUSY;
                        mem_rdy <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        if (!op_wr)
                            mbr <= ram[mar];
                        state   <= IDLE;
                        mem_rdy <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port.sv
// Scoreboard bench for mem_port: driver queues expected access results,
// monitor checks them when mem_rdy returns high.
module tb_mem_port;

    localparam int WC = 1;
`ifdef MEM_PORT_WPROT_EN
    localparam bit PROT = 1'b1;
`else
    localparam bit PROT = 1'b0;
`endif

    logic       mem_clk = 1'b0;
    logic       mem_rst_n = 1'b1;
    logic       MAR_we = 1'b0;
    logic [1:0] RAM_in = 2'b00;
    logic       PC_inc = 1'b0;
    logic       MBR_we = 1'b0;
    logic       RAM_we = 1'b0;
    logic [7:0] ir_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic       mem_rdy;
    logic [7:0] mbr;
    logic [7:0] mar;
    logic [7:0] pc;
    logic       prot_err;

    mem_port #(
        .ADDR_W(8), .DATA_W(8), .WAIT_CYCLES(WC), .PROT_LIMIT(16)
    ) dut (
        .mem_clk(mem_clk), .mem_rst_n(mem_rst_n),
        .MAR_we(MAR_we), .RAM_in(RAM_in), .PC_inc(PC_inc),
        .MBR_we(MBR_we), .RAM_we(RAM_we),
        .ir_addr(ir_addr), .wr_data(wr_data),
        .mem_rdy(mem_rdy), .mbr(mbr), .mar(mar), .pc(pc),
        .prot_err(prot_err)
    );

    always #5 mem_clk = ~mem_clk;

    typedef struct {
        string      name;
        logic [7:0] mbr;
        bit         perr;
        bit         ne;
    } exp_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] mbr_m = 8'h00;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic push(input string nm, input logic [7:0] m,
                        input bit pe, input bit ne);
        exp_t e;
        e.name = nm;
        e.mbr  = m;
        e.perr = pe;
        e.ne   = ne;
        sb.push_back(e);
    endtask

    // Monitor: one completion per mem_rdy rise outside reset
    initial begin
        bit prev = 1'b1;
        int low = 0;
        exp_t e;
        forever begin
            @(negedge mem_clk);
            if (!mem_rst_n) begin
                prev = 1'b1;
                low  = 0;
            end else if (!mem_rdy) begin
                low++;
                prev = 1'b0;
                if (prot_err)
                    check("perr_busy", {31'd0, prot_err}, 32'd0);
            end else if (!prev) begin
                prev = 1'b1;
                if (sb.size() == 0) begin
                    check("unexp_access", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.name, "_busy"}, low, WC + 1);
                    if (e.ne) begin
                        n_cmp++;
                        if (mbr === e.mbr) begin
                            n_err++;
                            $display("FAIL %s_mbr: got %0h must differ from %0h",
                                     e.name, mbr, e.mbr);
                        end
                    end else begin
                        check({e.name, "_mbr"}, mbr, e.mbr);
                    end
                    check({e.name, "_perr"}, {31'd0, prot_err}, {31'd0, e.perr});
                end
                low = 0;
            end else if (prot_err) begin
                check("perr_idle", {31'd0, prot_err}, 32'd0);
            end
        end
    end

    task automatic issue(input bit mw, input logic [1:0] ri,
                         input logic [7:0] ia, input bit pi,
                         input bit bw, input bit rw, input logic [7:0] wd);
        @(negedge mem_clk);
        MAR_we = mw; RAM_in = ri; ir_addr = ia; PC_inc = pi;
        MBR_we = bw; RAM_we = rw; wr_data = wd;
        @(negedge mem_clk);
        MAR_we = 0; RAM_in = 2'b00; ir_addr = 8'h00; PC_inc = 0;
        MBR_we = 0; RAM_we = 0; wr_data = 8'h00;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            if (mem_rdy)
                return;
            @(negedge mem_clk);
        end
        check("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic set_mar(input logic [7:0] a);
        issue(1, 2'b01, a, 0, 0, 0, 8'h00);
        check("set_mar", mar, a);
    endtask

    task automatic do_write(input string nm, input logic [7:0] d,
                            input bit pe);
        push(nm, mbr_m, pe, 0);
        issue(0, 2'b00, 8'h00, 0, 0, 1, d);
        wait_idle();
    endtask

    task automatic do_read(input string nm, input logic [7:0] d,
                           input bit ne);
        push(nm, d, 0, ne);
        mbr_m = d;
        issue(0, 2'b00, 8'h00, 0, 1, 0, 8'h00);
        wait_idle();
    endtask

    initial begin
        // asynchronous reset, checked before any clock edge
        #1 mem_rst_n = 0;
        #1;
        check("rst_pc", pc, 0);
        check("rst_mar", mar, 0);
        check("rst_mbr", mbr, 0);
        check("rst_rdy", {31'd0, mem_rdy}, 1);
        check("rst_perr", {31'd0, prot_err}, 0);
        @(negedge mem_clk);
        mem_rst_n = 1;

        set_mar(8'h40);
        do_write("wr40", 8'hA5, 0);
        do_read("rd40", 8'hA5, 0);

        // both strobes: write wins, mbr untouched
        set_mar(8'h20);
        push("both", mbr_m, 0, 0);
        issue(0, 2'b00, 8'h00, 0, 1, 1, 8'h3C);
        wait_idle();
        do_read("rd20", 8'h3C, 0);

        // strobes during BUSY are ignored
        set_mar(8'h40);
        push("rdbusy", 8'hA5, 0, 0);
        mbr_m = 8'hA5;
        issue(0, 2'b00, 8'h00, 0, 1, 0, 8'h00);
        issue(1, 2'b01, 8'h99, 0, 1, 0, 8'h00);
        check("busy_mar", mar, 8'h40);
        wait_idle();
        check("busy_mar2", mar, 8'h40);

        // pc wrap and pre-increment capture
        @(negedge mem_clk);
        PC_inc = 1;
        repeat (255) @(negedge mem_clk);
        PC_inc = 0;
        check("pc_ff", pc, 8'hFF);
        issue(1, 2'b00, 8'h00, 1, 0, 0, 8'h00);
        check("wrap_pc", pc, 8'h00);
        check("wrap_mar", mar, 8'hFF);
        issue(1, 2'b11, 8'h12, 0, 0, 0, 8'h00);
        check("hold_mar", mar, 8'hFF);
        issue(1, 2'b10, 8'h12, 0, 0, 0, 8'h00);
        check("mbr_mar", mar, 8'hA5);

        // write protection boundary
        set_mar(8'h05);
        do_write("wr05", 8'h77, PROT);
        set_mar(8'h10);
        do_write("wr10", 8'h5A, 0);
        do_read("rd10", 8'h5A, 0);
        set_mar(8'h05);
        do_read("rd05", 8'h77, PROT);

        // reset in the middle of a write
        set_mar(8'h10);
        @(negedge mem_clk);
        RAM_we = 1; wr_data = 8'hEE; PC_inc = 1;
        @(posedge mem_clk);
        #2;
        check("pre_rst_rdy", {31'd0, mem_rdy}, 0);
        mem_rst_n = 0;
        RAM_we = 0; wr_data = 8'h00; PC_inc = 0;
        #1;
        check("mid_rst_rdy", {31'd0, mem_rdy}, 1);
        check("mid_rst_pc", pc, 0);
        check("mid_rst_mar", mar, 0);
        check("mid_rst_mbr", mbr, 0);
        @(negedge mem_clk);
        @(negedge mem_clk);
        mem_rst_n = 1;
        mbr_m = 8'h00;
        set_mar(8'h10);
        do_read("rd10_post", 8'h5A, 0);

        repeat (3) @(negedge mem_clk);
        check("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
